// File: rtl/ultra_cmd_parser.sv
// ASCII command parser for the ultrasonic parking unit: 'R'<digits><CR> sets the
// threshold of the selected channel, 'C'<digits><CR> selects a channel.
//   state     | meaning
//   ST_IDLE   | waiting for an 'R' or 'C' opcode, other bytes ignored
//   ST_DIGITS | frame open, accumulating decimal digits until CR
//   ST_FLUSH  | frame rejected, discarding bytes up to the next CR
module ultra_cmd_parser #(
  parameter int MAX_DIGITS   = 3,
  parameter int VAL_W        = 10,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int RESET_THRESH = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [NUM_CH*VAL_W-1:0]   thresh_flat,
  output logic [CH_W-1:0]           cur_ch,
  output logic                      cmd_done,
  output logic                      cmd_err,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIGITS = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam int AW = VAL_W + 4;
  localparam logic [AW-1:0] MAX_VAL  = AW'((64'd1 << VAL_W) - 64'd1);
  localparam logic [AW-1:0] CH_LIMIT = AW'(NUM_CH);
  localparam logic [2:0]    MAX_CNT  = 3'(MAX_DIGITS);

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [1:0]       state, state_nxt;
  logic             op_c;
  logic [AW-1:0]    acc, acc_nxt;
  logic [2:0]       cnt;
  logic [VAL_W-1:0] thresh [NUM_CH];

  logic is_digit, start, take, commit_r, commit_c, err;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // acc is bounded by MAX_VAL, so acc*10+9 always fits in AW bits
  assign acc_nxt  = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, rx_data[3:0]};

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take      = 1'b0;
    commit_r  = 1'b0;
    commit_c  = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CH_R || rx_data == CH_C)) begin
          start     = 1'b1;
          state_nxt = ST_DIGITS;
        end
      end
      ST_DIGITS: begin
        if (rx_valid) begin
          if (is_digit) begin
            if (cnt == MAX_CNT || acc_nxt > MAX_VAL) begin
              err       = 1'b1;
              state_nxt = ST_FLUSH;
            end else begin
              take = 1'b1;
            end
          end else if (rx_data == CH_CR) begin
            state_nxt = ST_IDLE;
            if (cnt == 3'd0)          err      = 1'b1;
            else if (!op_c)           commit_r = 1'b1;
            else if (acc < CH_LIMIT)  commit_c = 1'b1;
            else                      err      = 1'b1;
          end else begin
            err       = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (rx_valid && rx_data == CH_CR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_c     <= 1'b0;
      acc      <= '0;
      cnt      <= 3'd0;
      cur_ch   <= '0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) thresh[k] <= VAL_W'(RESET_THRESH);
    end else begin
      state    <= state_nxt;
      cmd_done <= commit_r | commit_c;
      cmd_err  <= err;
      if (start) begin
        op_c <= (rx_data == CH_C);
        acc  <= '0;
        cnt  <= 3'd0;
      end else if (take) begin
        acc <= acc_nxt;
        cnt <= cnt + 3'd1;
      end
      if (commit_c) cur_ch <= acc[CH_W-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (commit_r && cur_ch == CH_W'(k)) thresh[k] <= acc[VAL_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign thresh_flat[g*VAL_W +: VAL_W] = thresh[g];
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ultra_cmd_parser.sv
// Scoreboard bench for ultra_cmd_parser: two builds (10-bit/4-channel and 8-bit/3-channel)
// share one byte stream; a frame-level reference model predicts each pulse and register set.
module tb_ultra_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [39:0] tf0;
  logic [1:0]  ch0;
  logic        done0, err0, busy0;
  logic [23:0] tf1;
  logic [1:0]  ch1;
  logic        done1, err1, busy1;

  ultra_cmd_parser #(.MAX_DIGITS(3), .VAL_W(10), .NUM_CH(4), .CH_W(2), .RESET_THRESH(100)) u_dut0 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .thresh_flat(tf0), .cur_ch(ch0), .cmd_done(done0), .cmd_err(err0), .busy(busy0));

  ultra_cmd_parser #(.MAX_DIGITS(3), .VAL_W(8), .NUM_CH(3), .CH_W(2), .RESET_THRESH(100)) u_dut1 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .thresh_flat(tf1), .cur_ch(ch1), .cmd_done(done1), .cmd_err(err1), .busy(busy1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               kind;   // 0 = cmd_done, 1 = cmd_err
    int               cyc;
    logic [3:0][9:0]  thr;
    logic [1:0]       ch;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  int m_thr [2][4];
  int m_ch  [2];
  int maxv  [2] = '{1023, 255};
  int nch   [2] = '{4, 3};
  int ev_idx[2] = '{-1, -1};
  bit ev_kind[2];

  logic [3:0][9:0] a0, a1;
  always_comb begin
    a0 = tf0;
    a1 = '0;
    for (int k = 0; k < 3; k++) a1[k] = {2'b00, tf1[k*8 +: 8]};
  end

  function automatic logic [3:0][9:0] model_thr(input int d);
    logic [3:0][9:0] r;
    r = '0;
    for (int k = 0; k < nch[d]; k++) r[k] = 10'(m_thr[d][k]);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ch[d] = 0;
      for (int k = 0; k < 4; k++) m_thr[d][k] = 100;
    end
  endtask

  task automatic push_exp(input int d);
    exp_t e;
    e.kind = ev_kind[d];
    e.cyc  = cyc + 1;
    e.thr  = model_thr(d);
    e.ch   = 2'(m_ch[d]);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_pulse(input int d, input logic dn, input logic er,
                             input logic [3:0][9:0] thr, input logic [1:0] ch);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (dn && er) begin
      tests++; fails++;
      $display("FAIL both_pulses dut%0d cyc=%0d done=1 err=1, required at most one", d, cyc);
    end
    if (dn || er) begin
      tests++;
      if (qs == 0) begin
        fails++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d done=%0b err=%0b, required no pulse", d, cyc, dn, er);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (er !== e.kind || e.cyc != cyc || thr !== e.thr || ch !== e.ch) begin
          fails++;
          $display("FAIL pulse dut%0d got err=%0b cyc=%0d thr=%h ch=%0d, required err=%0b cyc=%0d thr=%h ch=%0d",
                   d, er, cyc, thr, ch, e.kind, e.cyc, e.thr, e.ch);
        end
      end
    end else if (qs != 0) begin
      if (d == 0) e = q0[0];
      else        e = q1[0];
      if (e.cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_pulse dut%0d got none by cyc=%0d, required err=%0b at cyc=%0d", d, cyc, e.kind, e.cyc);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check_pulse(0, done0, err0, a0, ch0);
      check_pulse(1, done1, err1, a1, ch1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_thr0"}, 64'(a0), 64'(model_thr(0)));
    chk({tag, "_ch0"},  64'(ch0), 64'(m_ch[0]));
    chk({tag, "_thr1"}, 64'(a1), 64'(model_thr(1)));
    chk({tag, "_ch1"},  64'(ch1), 64'(m_ch[1]));
  endtask

  function automatic byte idle_junk();
    byte l [6] = '{8'h0A, 8'h20, 8'h78, 8'h35, 8'h0D, 8'h72};
    return l[$urandom_range(0, 5)];
  endfunction

  function automatic byte flush_junk();
    byte l [6] = '{8'h52, 8'h43, 8'h39, 8'h0A, 8'h20, 8'h30};
    return l[$urandom_range(0, 5)];
  endfunction

  task automatic send(input byte b, input int pos);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int d = 0; d < 2; d++) if (ev_idx[d] == pos) push_exp(d);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Outcome is derived from the frame's structure: digit string value/length, stray byte, opcode.
  task automatic frame(input byte op, input string ds, input byte bad, input int npre, input int npost);
    byte fb[$];
    int  op_idx, n, val;
    for (int i = 0; i < npre; i++) fb.push_back(idle_junk());
    op_idx = fb.size();
    fb.push_back(op);
    n = ds.len();
    for (int j = 0; j < n; j++) fb.push_back(ds[j]);
    if (bad != 0) begin
      fb.push_back(bad);
      for (int i = 0; i < npost; i++) fb.push_back(flush_junk());
    end
    fb.push_back(8'h0D);

    for (int d = 0; d < 2; d++) begin
      ev_idx[d]  = -1;
      ev_kind[d] = 1'b1;
      val = 0;
      for (int j = 0; j < n && ev_idx[d] < 0; j++) begin
        if (j >= 3) ev_idx[d] = op_idx + 1 + j;
        else begin
          val = val * 10 + (int'(ds[j]) - 48);
          if (val > maxv[d]) ev_idx[d] = op_idx + 1 + j;
        end
      end
      if (ev_idx[d] < 0) begin
        if (bad != 0) ev_idx[d] = op_idx + 1 + n;
        else begin
          ev_idx[d] = fb.size() - 1;
          if (n > 0) begin
            if (op == 8'h43) begin
              if (val < nch[d]) begin ev_kind[d] = 1'b0; m_ch[d] = val; end
            end else begin
              ev_kind[d] = 1'b0;
              m_thr[d][m_ch[d]] = val;
            end
          end
        end
      end
    end

    for (int i = 0; i < fb.size(); i++) begin
      send(fb[i], i);
      if (i == op_idx) begin
        chk("busy_open0", 64'(busy0), 64'd1);
        chk("busy_open1", 64'(busy1), 64'd1);
      end
    end
    ev_idx[0] = -1;
    ev_idx[1] = -1;
    chk("busy_closed0", 64'(busy0), 64'd0);
    chk("busy_closed1", 64'(busy1), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tf0"},  64'(tf0), 64'({4{10'd100}}));
    chk({tag, "_tf1"},  64'(tf1), 64'({3{8'd100}}));
    chk({tag, "_ch"},   64'({ch0, ch1}), 64'd0);
    chk({tag, "_puls"}, 64'({done0, err0, done1, err1}), 64'd0);
    chk({tag, "_busy"}, 64'({busy0, busy1}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    byte   op, bad;
    string s;
    int    nd, v;
    int    pw [5] = '{1, 10, 100, 1000, 10000};
    byte   bl [6] = '{8'h52, 8'h43, 8'h0A, 8'h20, 8'h2F, 8'h3A};

    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    frame(8'h52, "012", 0, 0, 0);
    check_regs("r012");
    frame(8'h43, "2", 0, 1, 0);
    frame(8'h52, "345", 0, 0, 0);
    check_regs("c2r345");
    frame(8'h52, "1234", 0, 0, 0);
    frame(8'h52, "5", 0, 0, 0);
    check_regs("r1234");
    frame(8'h43, "0", 0, 0, 0);
    frame(8'h43, "7", 0, 0, 0);
    frame(8'h52, "", 0, 0, 0);
    frame(8'h52, "", 8'h58, 0, 0);
    check_regs("errs");
    frame(8'h52, "255", 0, 0, 0);
    frame(8'h52, "256", 0, 0, 2);
    frame(8'h43, "3", 0, 0, 0);
    frame(8'h52, "999", 0, 0, 0);
    check_regs("bounds");

    // Abort a frame mid-way with reset; the trailing "4\r" must then be ignored.
    send(8'h52, -2);
    send(8'h33, -2);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h34, -2);
    send(8'h0D, -2);
    frame(8'h52, "7", 0, 0, 0);
    check_regs("afterrst");

    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) < 3) begin
        op = 8'h43;
        nd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : 1;
      end else begin
        op = 8'h52;
        nd = $urandom_range(0, 4);
      end
      v = (nd == 0) ? 0 : (op == 8'h43 && nd == 1) ? $urandom_range(0, 5) : $urandom_range(0, pw[nd] - 1);
      case (nd)
        1:       s = $sformatf("%01d", v);
        2:       s = $sformatf("%02d", v);
        3:       s = $sformatf("%03d", v);
        4:       s = $sformatf("%04d", v);
        default: s = "";
      endcase
      bad = ($urandom_range(0, 9) == 0) ? bl[$urandom_range(0, 5)] : 8'h00;
      frame(op, s, bad, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    check_regs("random");

    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
